regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file; successor to the 8-bit single-port file.
//  Provides two combinational read ports with write bypass, and an ALU writeback
//  path into the accumulator. An in-order load scoreboard marks registers awaiting
//  memory data and raises stall. Sits between the decoder/ULA and the memory unit.
// PARAMETERS
//  DATA_W    8   register width in bits
//  ADDR_W    4   address width; DEPTH = 2**ADDR_W entries
//  ACC_IDX   0   accumulator index; driven onto acc and written by ULA writeback
//  ZERO_IDX  15  hardwired-zero index; always reads 0, all writes ignored
//  LD_DEPTH  4   max outstanding loads (>=1)
// PORTS
//  clk            in   1       sole clock; rising edge
//  rst            in   1       one clock; reset is synchronous and active-low
//  we_reg         in   1       write enable, general port
//  waddr          in   ADDR_W  general write address
//  wdata          in   DATA_W  general write data
//  we_ula         in   1       ULA writeback enable (target ACC_IDX)
//  out_ula        in   DATA_W  ULA result
//  ld_issue       in   1       load issued; destination = ld_addr
//  ld_addr        in   ADDR_W  load destination register
//  ld_issue_ready out  1       tag FIFO not full
//  ld_valid       in   1       memory returns load data
//  ld_data        in   DATA_W  returned data
//  ld_ready       out  1       a load is pending (tag FIFO not empty)
//  raddr_a/raddr_b in  ADDR_W  read addresses
//  rdata_a/rdata_b out DATA_W  read data (combinational)
//  acc            out  DATA_W  registered accumulator contents (no bypass)
//  stall          out  1       raddr_a or raddr_b is busy
// BEHAVIOUR
//  - Reset (rst==0 at edge): all entries 0, tag FIFO emptied. Outputs then show:
//    acc=0, ld_ready=0, ld_issue_ready=1, stall=0, rdata=0.
//  - Issue accepted = ld_issue & ld_issue_ready. Pushes ld_addr; registers take
//    effect next edge. Return accepted = ld_valid & ld_ready. Pops head and writes
//    ld_data to the head address. Returns arrive in issue order.
//  - Return while empty: ignored (ld_ready=0). Issue while full: ignored.
//    Simultaneous accepted issue+return: push and pop both occur; count unchanged.
//  - busy[r] = any occupied FIFO entry holds r. This covers duplicate loads to r;
//    r clears only after its last return pops. ZERO_IDX is never busy.
//    A load to ZERO_IDX still occupies a slot; its return writes nothing.
//  - Same-edge write priority per register: load return > ULA (ACC_IDX) > we_reg.
//  - Writes to a busy register are performed; the later return overwrites (in-order WAW).
//  - Read bypass: if raddr matches the winning write of this cycle, rdata = that data.
//    Otherwise rdata = stored value. ZERO_IDX always reads 0.
//  - stall uses pre-edge FIFO contents: it stays high in the cycle of the final
//    return, while bypass already supplies the data.
//  - Reset mid-operation discards all pending loads. Later ld_valid is ignored.
// STRUCTURE
//  - Package regfile_pkg: ACC_IDX, ZERO_IDX, MADDR_IDX(14), and write-source enum
//    {WS_NONE, WS_REG, WS_ULA, WS_LD} for the priority mux.
//  - Sub-module ld_tag_fifo: LD_DEPTH x ADDR_W circular FIFO with push/pop,
//    full/empty and a per-entry valid+addr vector for busy compare.
//    Pointers wrap modulo LD_DEPTH; a count register separates full from empty.
// TESTING
//  1 Reset, then we_reg waddr=3 wdata=8'hA5, same-cycle raddr_a=3 -> rdata_a=A5
//    (bypass); next cycle still A5.
//  2 waddr=15 wdata=FF; read 15 -> 0. we_ula out_ula=3C with we_reg waddr=0 wdata=11
//    -> acc=3C next cycle.
//  3 ld_issue addr=5; raddr_a=5 -> stall=1. ld_valid data=77 -> rdata_a=77 that
//    cycle, stall=0 next cycle, reg5=77.
//  4 Issue 4 loads (LD_DEPTH=4) -> ld_issue_ready=0, 5th ignored. Returns 1..4
//    write in order. Pointers wrap on a 2nd pass.
//  5 Two loads to r2, then we_reg r2=9 -> stall held until 2nd return; final
//    r2 = 2nd return data.
//  6 rst=0 with 3 pending loads -> all regs 0, ld_ready=0. ld_valid afterwards ->
//    no register changes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
//   ACC_IDX   : accumulator index (ULA writeback target, driven onto acc)
//   ZERO_IDX  : hardwired-zero index (reads 0, writes ignored)
//   MADDR_IDX : memory-address register index, reserved for the memory unit
//   wsrc_e    : write source selected by the per-register priority mux
package regfile_pkg;

  localparam int unsigned ACC_IDX   = 0;
  localparam int unsigned ZERO_IDX  = 15;
  localparam int unsigned MADDR_IDX = 14;

  typedef enum logic [1:0] {
    WS_NONE,
    WS_REG,
    WS_ULA,
    WS_LD
  } wsrc_e;

endpackage

// File: rtl/ld_tag_fifo.sv
// In-order load tag FIFO: records destination registers of outstanding loads.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   push, push_addr   request to record a new load destination (dropped when full)
//   pop               request to retire the oldest load (dropped when empty)
//   full, empty       occupancy flags
//   head_addr         destination of the oldest outstanding load
//   ent_valid/addr    per-slot occupancy and destination, for busy compare
module ld_tag_fifo #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [ADDR_W-1:0]   push_addr,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [ADDR_W-1:0]   head_addr,
  output logic [LD_DEPTH-1:0] ent_valid,
  output logic [ADDR_W-1:0]   ent_addr [LD_DEPTH]
);

  localparam int unsigned PtrW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(LD_DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [LD_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;
  logic              push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count_q == CntW'(LD_DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_addr = addr_q[rptr_q];
  assign ent_addr  = addr_q;

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      ent_valid[i] = ((i + LD_DEPTH - 32'(rptr_q)) % LD_DEPTH) < 32'(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot contents need no reset: they are only observed while occupied.
  always_ff @(posedge clk) begin
    if (rst && push_ok) addr_q[wptr_q] <= push_addr;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, ULA writeback and load scoreboard.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   we_reg, waddr, wdata      general write port
//   we_ula, out_ula           ULA writeback into ACC_IDX
//   ld_issue, ld_addr         load issue (accepted when ld_issue_ready)
//   ld_valid, ld_data         load return (accepted when ld_ready), written in issue order
//   raddr_a/b, rdata_a/b      combinational read ports with same-cycle write bypass
//   acc                       registered accumulator contents
//   stall                     a read address awaits an outstanding load
module regfile_mp #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ACC_IDX  = regfile_pkg::ACC_IDX,
  parameter int unsigned ZERO_IDX = regfile_pkg::ZERO_IDX,
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_reg,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we_ula,
  input  logic [DATA_W-1:0] out_ula,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_issue_ready,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] acc,
  output logic              stall
);

  import regfile_pkg::*;

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   mem_d [Depth];
  wsrc_e               wsel  [Depth];
  logic [DATA_W-1:0]   wval  [Depth];

  logic                full, empty, ret_ok;
  logic [ADDR_W-1:0]   head_addr;
  logic [LD_DEPTH-1:0] ent_valid;
  logic [ADDR_W-1:0]   ent_addr [LD_DEPTH];
  logic [Depth-1:0]    busy;

  ld_tag_fifo #(
    .ADDR_W   (ADDR_W),
    .LD_DEPTH (LD_DEPTH)
  ) u_ld_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ld_issue),
    .push_addr (ld_addr),
    .pop       (ld_valid),
    .full      (full),
    .empty     (empty),
    .head_addr (head_addr),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  assign ld_issue_ready = ~full;
  assign ld_ready       = ~empty;
  assign ret_ok         = ld_valid & ~empty;

  // Per-register write source: load return > ULA > general port.
  always_comb begin
    for (int unsigned r = 0; r < Depth; r++) begin
      wsel[r] = WS_NONE;
      wval[r] = '0;
      if (r != ZERO_IDX) begin
        if (ret_ok && head_addr == ADDR_W'(r)) begin
          wsel[r] = WS_LD;
          wval[r] = ld_data;
        end else if (we_ula && r == ACC_IDX) begin
          wsel[r] = WS_ULA;
          wval[r] = out_ula;
        end else if (we_reg && waddr == ADDR_W'(r)) begin
          wsel[r] = WS_REG;
          wval[r] = wdata;
        end
      end
      mem_d[r] = (wsel[r] != WS_NONE) ? wval[r] : mem_q[r];
    end
  end

  // mem_d already holds this cycle's winning write, so reading it is the bypass.
  assign rdata_a = (raddr_a == ADDR_W'(ZERO_IDX)) ? '0 : mem_d[raddr_a];
  assign rdata_b = (raddr_b == ADDR_W'(ZERO_IDX)) ? '0 : mem_d[raddr_b];
  assign acc     = mem_q[ACC_IDX];

  always_comb begin
    busy = '0;
    for (int unsigned i = 0; i < LD_DEPTH; i++) begin
      if (ent_valid[i]) busy[ent_addr[i]] = 1'b1;
    end
    busy[ZERO_IDX] = 1'b0;
  end

  assign stall = busy[raddr_a] | busy[raddr_b];

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < Depth; r++) begin
      if (!rst) mem_q[r] <= '0;
      else      mem_q[r] <= mem_d[r];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic       clk = 1'b0;
  logic       rst;
  logic       we_reg;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       we_ula;
  logic [7:0] out_ula;
  logic       ld_issue;
  logic [3:0] ld_addr;
  logic       ld_issue_ready;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [3:0] raddr_a, raddr_b;
  logic [7:0] rdata_a, rdata_b;
  logic [7:0] acc;
  logic       stall;

  regfile_mp dut (
    .clk            (clk),
    .rst            (rst),
    .we_reg         (we_reg),
    .waddr          (waddr),
    .wdata          (wdata),
    .we_ula         (we_ula),
    .out_ula        (out_ula),
    .ld_issue       (ld_issue),
    .ld_addr        (ld_addr),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .raddr_a        (raddr_a),
    .raddr_b        (raddr_b),
    .rdata_a        (rdata_a),
    .rdata_b        (rdata_b),
    .acc            (acc),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register values plus a queue of pending load destinations.
  logic [7:0] mreg [16];
  int         ldq [$];
  bit         model_ok = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Value register idx holds once this cycle's writes land (what a read must see).
  function automatic logic [7:0] eff_val(int idx);
    logic [7:0] v;
    if (idx == 15) return 8'h00;
    v = mreg[idx];
    if (we_reg && int'(waddr) == idx) v = wdata;
    if (we_ula && idx == 0) v = out_ula;
    if (ld_valid && ldq.size() > 0 && ldq[0] == idx) v = ld_data;
    return v;
  endfunction

  function automatic bit is_busy(int idx);
    if (idx == 15) return 1'b0;
    foreach (ldq[k]) if (ldq[k] == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Compare at negedge, then advance the model at the following posedge.
  initial begin
    logic [7:0] nxt [16];
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("rdata_a", rdata_a, eff_val(int'(raddr_a)));
        check("rdata_b", rdata_b, eff_val(int'(raddr_b)));
        check("acc", acc, mreg[0]);
        check("stall", stall, is_busy(int'(raddr_a)) || is_busy(int'(raddr_b)));
        check("ld_ready", ld_ready, ldq.size() > 0);
        check("ld_issue_ready", ld_issue_ready, ldq.size() < 4);
      end
      @(posedge clk);
      if (!rst) begin
        foreach (mreg[i]) mreg[i] = 8'h00;
        ldq.delete();
        model_ok = 1'b1;
      end else if (model_ok) begin
        bit ret, iss;
        ret = ld_valid && ldq.size() > 0;
        iss = ld_issue && ldq.size() < 4;
        foreach (nxt[i]) nxt[i] = eff_val(i);
        mreg = nxt;
        if (ret) void'(ldq.pop_front());
        if (iss) ldq.push_back(int'(ld_addr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_reg = 0; we_ula = 0; ld_issue = 0; ld_valid = 0;
  endtask

  initial begin
    rst = 0; idle();
    waddr = 0; wdata = 0; out_ula = 0; ld_addr = 0; ld_data = 0;
    raddr_a = 0; raddr_b = 0;
    step(); step();
    rst = 1;
    #1;
    check("reset acc", acc, 8'h00);
    check("reset ld_ready", ld_ready, 1'b0);
    check("reset ld_issue_ready", ld_issue_ready, 1'b1);
    check("reset stall", stall, 1'b0);
    check("reset rdata_a", rdata_a, 8'h00);

    // Write bypass then stored value.
    we_reg = 1; waddr = 3; wdata = 8'hA5; raddr_a = 3;
    #1 check("bypass r3", rdata_a, 8'hA5);
    step(); idle();
    #1 check("stored r3", rdata_a, 8'hA5);

    // Zero register and ULA priority over general port.
    we_reg = 1; waddr = 15; wdata = 8'hFF; raddr_a = 15;
    #1 check("zero read", rdata_a, 8'h00);
    step(); idle();
    we_ula = 1; out_ula = 8'h3C; we_reg = 1; waddr = 0; wdata = 8'h11;
    step(); idle();
    #1 check("acc ula wins", acc, 8'h3C);

    // Single load with bypass on return.
    ld_issue = 1; ld_addr = 5; raddr_a = 5;
    step(); idle();
    #1 check("stall on load", stall, 1'b1);
    ld_valid = 1; ld_data = 8'h77;
    #1 check("load bypass", rdata_a, 8'h77);
    check("stall in return cycle", stall, 1'b1);
    step(); idle();
    #1 check("stall cleared", stall, 1'b0);
    check("r5 loaded", rdata_a, 8'h77);

    // Fill the tag FIFO twice to exercise pointer wrap.
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        ld_issue = 1; ld_addr = 4'(6 + 4 * p + k);
        step();
      end
      idle();
      #1 check("fifo full", ld_issue_ready, 1'b0);
      ld_issue = 1; ld_addr = 1;
      step(); idle();
      for (int k = 0; k < 4; k++) begin
        ld_valid = 1; ld_data = 8'(16 * p + k + 1);
        step();
      end
      idle();
      #1 check("fifo drained", ld_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
        raddr_a = 4'(6 + 4 * p + k);
        #1 check("in-order return", rdata_a, 8'(16 * p + k + 1));
      end
      raddr_a = 1;
      #1 check("5th issue ignored", rdata_a, 8'h00);
    end

    // Duplicate loads to r2 with an intervening write.
    ld_issue = 1; ld_addr = 2; step();
    ld_issue = 1; ld_addr = 2; step(); idle();
    we_reg = 1; waddr = 2; wdata = 8'h09; raddr_a = 2; step(); idle();
    #1 check("r2 stall", stall, 1'b1);
    ld_valid = 1; ld_data = 8'h21; step(); idle();
    #1 check("r2 still busy", stall, 1'b1);
    check("r2 first return", rdata_a, 8'h21);
    ld_valid = 1; ld_data = 8'h42; step(); idle();
    #1 check("r2 free", stall, 1'b0);
    check("r2 final", rdata_a, 8'h42);

    // Reset with pending loads discards them.
    for (int k = 0; k < 3; k++) begin
      ld_issue = 1; ld_addr = 4'(7 + k); step();
    end
    idle();
    rst = 0; step(); rst = 1;
    raddr_a = 3;
    #1 check("rst ld_ready", ld_ready, 1'b0);
    check("rst r3", rdata_a, 8'h00);
    check("rst acc", acc, 8'h00);
    ld_valid = 1; ld_data = 8'hEE; raddr_a = 7;
    step(); idle();
    #1 check("stale return ignored", rdata_a, 8'h00);

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 249) != 0);
      we_reg   = 1'($urandom);
      waddr    = 4'($urandom);
      wdata    = 8'($urandom);
      we_ula   = ($urandom_range(0, 3) == 0);
      out_ula  = 8'($urandom);
      ld_issue = ($urandom_range(0, 9) < 4);
      ld_addr  = 4'($urandom);
      ld_valid = ($urandom_range(0, 9) < 4);
      ld_data  = 8'($urandom);
      raddr_a  = ($urandom_range(0, 1) != 0) ? ld_addr : 4'($urandom);
      raddr_b  = 4'($urandom);
      step();
    end
    idle(); rst = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
